add_arb_ctrl: RTL and testbench

- Round-robin arbiter and sequencer that shares one fixed-latency adder datapath between NUM_REQ requesters.
- Accepts operand pairs over valid/ready and issues them to the adder's add_in side.
- Tracks the owner of each in-flight operation in a tag pipeline and routes each add_out result back to the requester that issued it.
- Provides drain/halt control so software or a sequencer can quiesce the adder.

---
 rtl/add_arb_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/add_arb_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_add_arb_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// Shared types for the adder arbiter: FSM states, in-flight tag and default widths.
// Imported by add_arb_ctrl.
package add_arb_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_RES_W  = DEF_DATA_W + 1;
    // Fixed tag index width covers the largest supported NUM_REQ (8).
    localparam int unsigned TAG_IDX_W  = 3;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 vld;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [TAG_IDX_W-1:0] oh_to_idx(input logic [7:0] oh);
        logic [TAG_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = i[TAG_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered pointer; the search starts just above the
// last granted index. Reset points at NUM_REQ-1 so requester 0 has first priority.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        gnt       = '0;
        w_gnt_idx = r_ptr;
        w_cand    = r_ptr;
        w_found   = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % int'(NUM_REQ));
            if (enable && !w_found && req[w_cand]) begin
                gnt[w_cand] = 1'b1;
                w_gnt_idx   = w_cand;
                w_found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= PTR_W'(NUM_REQ - 1);
        end else if (advance && w_found) begin
            r_ptr <= w_gnt_idx;
        end
    end

endmodule

// File: rtl/add_arb_ctrl.sv
// Shares one fixed-latency adder between NUM_REQ requesters with tag-based routing and
// drain/halt control. Define ADD_ARB_STATS_EN to add per-requester grant counters.
module add_arb_ctrl
    import add_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADD_LATENCY = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      add_in_valid,
    output logic [DATA_W-1:0]         add_in_a,
    output logic [DATA_W-1:0]         add_in_b,
    input  logic                      add_out_valid,
    input  logic [DATA_W:0]           add_out_result,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W:0]           rsp_result,
    input  logic                      drain_req,
    output logic                      drain_done,
    output logic                      busy,
    output logic                      protocol_err
`ifdef ADD_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(ADD_LATENCY + 2);

    arb_state_e           r_state;
    logic                 r_drain_done;
    logic                 r_add_in_valid;
    logic [DATA_W-1:0]    r_add_in_a;
    logic [DATA_W-1:0]    r_add_in_b;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W:0]      r_rsp_result;
    logic                 r_protocol_err;
    logic [CNT_W-1:0]     r_cnt;
    tag_t                 r_tag [ADD_LATENCY+1];

    logic                 w_arb_en;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_hs;
    logic [TAG_IDX_W-1:0] w_gnt_idx;
    logic [DATA_W-1:0]    w_sel_a;
    logic [DATA_W-1:0]    w_sel_b;
    tag_t                 w_tail;
    logic                 w_rsp;
    logic [NUM_REQ-1:0]   w_rsp_oh;

    // Reset also blocks grants so nothing is accepted while the pipe is being cleared.
    assign w_arb_en  = (r_state == StRun) && !drain_req && !reset;
    assign w_hs      = |(req_valid & w_gnt);
    assign w_gnt_idx = oh_to_idx(8'(w_gnt));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clock   (clock),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_hs),
        .enable  (w_arb_en),
        .gnt     (w_gnt)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_a[i*DATA_W +: DATA_W];
                w_sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_add_in_valid <= 1'b0;
            r_add_in_a     <= '0;
            r_add_in_b     <= '0;
        end else begin
            r_add_in_valid <= w_hs;
            if (w_hs) begin
                r_add_in_a <= w_sel_a;
                r_add_in_b <= w_sel_b;
            end
        end
    end

    // Stage 0 lines up with add_in_valid; stage ADD_LATENCY lines up with add_out_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= int'(ADD_LATENCY); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_hs, idx: w_gnt_idx};
            for (int i = 1; i <= int'(ADD_LATENCY); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tail = r_tag[ADD_LATENCY];
    assign w_rsp  = w_tail.vld && add_out_valid;

    always_comb begin
        w_rsp_oh = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_rsp && (w_tail.idx == i[TAG_IDX_W-1:0])) begin
                w_rsp_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid    <= '0;
            r_rsp_result   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_oh;
            if (w_rsp) begin
                r_rsp_result <= add_out_result;
            end
            if (w_tail.vld != add_out_valid) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_hs, w_rsp})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StRun;
            r_drain_done <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (drain_req) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    // Completes even if drain_req drops; HALTED then exits on the next cycle.
                    if ((r_cnt == '0) && !r_add_in_valid) begin
                        r_state      <= StHalted;
                        r_drain_done <= 1'b1;
                    end
                end
                StHalted: begin
                    if (!drain_req) begin
                        r_state      <= StRun;
                        r_drain_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= StRun;
                    r_drain_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADD_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        always_ff @(posedge clock) begin
            if (reset) begin
                r_grant_cnt[g] <= '0;
            end else if (w_hs && w_gnt[g] && (r_grant_cnt[g] != 16'hFFFF)) begin
                r_grant_cnt[g] <= r_grant_cnt[g] + 16'd1;
            end
        end
        assign grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
`endif

    assign req_ready    = w_gnt;
    assign add_in_valid = r_add_in_valid;
    assign add_in_a     = r_add_in_a;
    assign add_in_b     = r_add_in_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign drain_done   = r_drain_done;
    assign protocol_err = r_protocol_err;
    assign busy         = !reset && ((r_cnt != '0) || r_add_in_valid);

endmodule

// File: tb/tb_add_arb_ctrl.sv
// Scoreboard bench for add_arb_ctrl with a behavioural fixed-latency adder.
// Expected grants come from a round-robin model; expected sums from the driven operands.
module tb_add_arb_ctrl;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic             add_in_valid;
    logic [DW-1:0]    add_in_a;
    logic [DW-1:0]    add_in_b;
    logic             add_out_valid;
    logic [DW:0]      add_out_result;
    logic [NR-1:0]    rsp_valid;
    logic [DW:0]      rsp_result;
    logic             drain_req;
    logic             drain_done;
    logic             busy;
    logic             protocol_err;

    add_arb_ctrl #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .ADD_LATENCY (LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .add_in_valid   (add_in_valid),
        .add_in_a       (add_in_a),
        .add_in_b       (add_in_b),
        .add_out_valid  (add_out_valid),
        .add_out_result (add_out_result),
        .rsp_valid      (rsp_valid),
        .rsp_result     (rsp_result),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .busy           (busy),
        .protocol_err   (protocol_err)
    );

    typedef struct {
        int          idx;
        logic [DW:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk    = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rsp_seen = 0;
    int          tb_last  = NR - 1;
    logic        inj      = 1'b0;
    logic        s_vld [LAT];
    logic [DW:0] s_res [LAT];

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [NR-1:0] exp_gnt(input logic [NR-1:0] v, input int last);
        logic [NR-1:0] g;
        int            j;
        g = '0;
        for (int k = 1; k <= NR; k++) begin
            j = (last + k) % NR;
            if (v[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Behavioural adder: result appears LAT cycles after add_in_valid; inj adds a stray pulse.
    initial begin
        add_out_valid  = 1'b0;
        add_out_result = '0;
        for (int k = 0; k < LAT; k++) begin
            s_vld[k] = 1'b0;
            s_res[k] = '0;
        end
        forever begin
            @(negedge clock);
            if (reset) begin
                add_out_valid = 1'b0;
                for (int k = 0; k < LAT; k++) begin
                    s_vld[k] = 1'b0;
                end
            end else begin
                add_out_valid  = s_vld[LAT-1] | inj;
                add_out_result = s_res[LAT-1];
                for (int k = LAT - 1; k > 0; k--) begin
                    s_vld[k] = s_vld[k-1];
                    s_res[k] = s_res[k-1];
                end
                s_vld[0] = add_in_valid;
                s_res[0] = {1'b0, add_in_a} + {1'b0, add_in_b};
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (rsp_valid != '0) begin
            rsp_seen++;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                check("rsp_route", 32'(rsp_valid), 32'(1) << mon_e.idx);
                check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
                check("rsp_latency", 32'(cyc - mon_e.cyc), 32'(LAT + 2));
            end
        end
    end

    task automatic drive(input logic [NR-1:0] v, input logic drn, input logic exp_en,
                         input logic [NR*DW-1:0] a, input logic [NR*DW-1:0] b);
        logic [NR-1:0] eg;
        exp_t          e;
        @(negedge clock);
        req_valid = v;
        drain_req = drn;
        req_a     = a;
        req_b     = b;
        #1;
        eg = exp_en ? exp_gnt(v, tb_last) : '0;
        check("req_ready", 32'(req_ready), 32'(eg));
        for (int i = 0; i < NR; i++) begin
            if (eg[i]) begin
                e.idx   = i;
                e.res   = {1'b0, a[i*DW +: DW]} + {1'b0, b[i*DW +: DW]};
                e.cyc   = cyc;
                sb.push_back(e);
                tb_last = i;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            drive('0, 1'b0, 1'b1, '0, '0);
            n++;
        end
        check("idle_reached", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int rs0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        drain_req = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        req_valid = '1;
        #1;
        check("reset_ready", 32'(req_ready), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_add_in_valid", 32'(add_in_valid), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_drain_done", 32'(drain_done), 32'(0));
        check("reset_protocol_err", 32'(protocol_err), 32'(0));
        @(negedge clock);
        reset     = 1'b0;
        req_valid = '0;

        // Single request from requester 0.
        drive(4'b0001, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0003);
        drive('0, 1'b0, 1'b1, '0, '0);
        check("issue_valid", 32'(add_in_valid), 32'(1));
        check("issue_a", 32'(add_in_a), 32'h05);
        check("issue_b", 32'(add_in_b), 32'h03);
        wait_idle(10);

        // All requesters valid back-to-back with random operands.
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 1'b0, 1'b1, $urandom, $urandom);
        end
        wait_idle(20);

        // Carry out of the operand width.
        drive(4'b0100, 1'b0, 1'b1, 32'h00FF_0000, 32'h0001_0000);
        wait_idle(10);

        // Drain with two operations in flight.
        drive(4'b0010, 1'b0, 1'b1, 32'h0000_1100, 32'h0000_2200);
        drive(4'b1000, 1'b0, 1'b1, 32'h8000_0000, 32'h9000_0000);
        drive(4'b1111, 1'b1, 1'b0, 32'h0101_0101, 32'h0202_0202);
        check("drain_busy", 32'(busy), 32'(1));
        for (int k = 0; k < 20; k++) begin
            drive(4'b1111, 1'b1, 1'b0, 32'h0101_0101, 32'h0202_0202);
            if (drain_done) break;
        end
        check("drain_done", 32'(drain_done), 32'(1));
        check("drain_empty", 32'(sb.size()), 32'(0));
        check("drain_idle", 32'(busy), 32'(0));
        drive(4'b1111, 1'b0, 1'b0, 32'h0303_0303, 32'h0404_0404);
        check("halted_hold", 32'(drain_done), 32'(1));
        drive(4'b1111, 1'b0, 1'b1, 32'h0505_0505, 32'h0606_0606);
        check("resume_drain_done", 32'(drain_done), 32'(0));
        wait_idle(10);

        // Stray adder result with an empty tag pipe.
        check("perr_before", 32'(protocol_err), 32'(0));
        inj = 1'b1;
        drive('0, 1'b0, 1'b1, '0, '0);
        inj = 1'b0;
        drive('0, 1'b0, 1'b1, '0, '0);
        check("perr_set", 32'(protocol_err), 32'(1));
        repeat (3) drive('0, 1'b0, 1'b1, '0, '0);
        check("perr_sticky", 32'(protocol_err), 32'(1));

        // Reset with three operations in flight.
        repeat (3) drive(4'b1111, 1'b0, 1'b1, $urandom, $urandom);
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '1;
        sb.delete();
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        @(negedge clock);
        #1;
        check("rst_busy2", 32'(busy), 32'(0));
        check("rst_ready2", 32'(req_ready), 32'(0));
        check("rst_perr_clear", 32'(protocol_err), 32'(0));
        @(negedge clock);
        reset     = 1'b0;
        req_valid = '0;
        tb_last   = NR - 1;
        rs0       = rsp_seen;
        repeat (6) drive('0, 1'b0, 1'b1, '0, '0);
        check("rst_no_rsp", 32'(rsp_seen - rs0), 32'(0));
        check("rst_no_perr", 32'(protocol_err), 32'(0));
        drive(4'b1111, 1'b0, 1'b1, 32'h1122_3344, 32'h0102_0304);
        wait_idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
